// File: rtl/issue_queue_nxm_pkg.sv
// rtl/issue_queue_nxm_pkg.sv - shared defaults and sizing helpers for the N-in/M-out issue queue
//
// Holds the default geometry used by the queue, its bus interface and the
// bench, plus the helper that sizes the occupancy counter.

package issue_queue_nxm_pkg;

    localparam int DEF_DEPTH     = 16;
    localparam int DEF_N_IN      = 4;
    localparam int DEF_N_OUT     = 2;
    localparam int DEF_N_WB      = 4;
    localparam int DEF_WIDTH_TAG = 6;
    localparam int DEF_WIDTH_BRM = 3;
    localparam int DEF_WIDTH_PL  = 32;

    // Counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/issue_queue_nxm_if.sv
// rtl/issue_queue_nxm_if.sv - dispatch/wakeup/kill/issue bundle of the issue queue
//
// master: rename/dispatch + writeback + branch unit side (drives i_*)
// slave : the issue queue itself (drives o_*)
//   i_valid/i_payload/i_src*_tag/i_src*_rdy/i_brm : per-lane dispatch, lane 0 in LSBs
//   o_in_ready                                    : a full dispatch group fits
//   i_wb_valid/i_wb_tag                           : wakeup tag ports
//   i_kill_en/i_kill_mask                         : branch kill
//   i_stall                                       : suppress issue
//   o_issue_valid/o_issue_payload/o_issue_brm     : issue ports, port 0 oldest
//   o_count                                       : registered occupancy

interface issue_queue_nxm_if
    import issue_queue_nxm_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int N_IN      = DEF_N_IN,
    parameter int N_OUT     = DEF_N_OUT,
    parameter int N_WB      = DEF_N_WB,
    parameter int WIDTH_TAG = DEF_WIDTH_TAG,
    parameter int WIDTH_BRM = DEF_WIDTH_BRM,
    parameter int WIDTH_PL  = DEF_WIDTH_PL
);

    localparam int CW = count_w(DEPTH);

    logic [N_IN-1:0]           i_valid;
    logic [N_IN*WIDTH_PL-1:0]  i_payload;
    logic [N_IN*WIDTH_TAG-1:0] i_src1_tag;
    logic [N_IN*WIDTH_TAG-1:0] i_src2_tag;
    logic [N_IN-1:0]           i_src1_rdy;
    logic [N_IN-1:0]           i_src2_rdy;
    logic [N_IN*WIDTH_BRM-1:0] i_brm;
    logic                      o_in_ready;
    logic [N_WB-1:0]           i_wb_valid;
    logic [N_WB*WIDTH_TAG-1:0] i_wb_tag;
    logic                      i_kill_en;
    logic [WIDTH_BRM-1:0]      i_kill_mask;
    logic                      i_stall;
    logic [N_OUT-1:0]          o_issue_valid;
    logic [N_OUT*WIDTH_PL-1:0] o_issue_payload;
    logic [N_OUT*WIDTH_BRM-1:0] o_issue_brm;
    logic [CW-1:0]             o_count;

    modport master (
        output i_valid, i_payload, i_src1_tag, i_src2_tag, i_src1_rdy, i_src2_rdy, i_brm,
        output i_wb_valid, i_wb_tag, i_kill_en, i_kill_mask, i_stall,
        input  o_in_ready, o_issue_valid, o_issue_payload, o_issue_brm, o_count
    );

    modport slave (
        input  i_valid, i_payload, i_src1_tag, i_src2_tag, i_src1_rdy, i_src2_rdy, i_brm,
        input  i_wb_valid, i_wb_tag, i_kill_en, i_kill_mask, i_stall,
        output o_in_ready, o_issue_valid, o_issue_payload, o_issue_brm, o_count
    );

endinterface

// File: rtl/issue_queue_nxm_select.sv
// rtl/issue_queue_nxm_select.sv - oldest-first N_OUT-port grant selector
//
// req         : DEPTH-wide request vector, bit 0 = oldest slot
// grant[k]    : one-hot grant for port k (k-th oldest requester)
// grant_valid : port k found a requester
//
// Chain of find-first stages; each stage masks off the previous grant so
// port k sees only requesters younger than port k-1's winner.

module iq_select #(
    parameter int DEPTH = 16,
    parameter int N_OUT = 2
) (
    input  logic [DEPTH-1:0]            req,
    output logic [N_OUT-1:0][DEPTH-1:0] grant,
    output logic [N_OUT-1:0]            grant_valid
);

    logic [DEPTH-1:0] remain;
    logic             found;

    always_comb begin
        remain      = req;
        found       = 1'b0;
        grant       = '0;
        grant_valid = '0;
        for (int k = 0; k < N_OUT; k++) begin
            found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && remain[i]) begin
                    grant[k][i] = 1'b1;
                    found       = 1'b1;
                end
            end
            grant_valid[k] = found;
            remain         = remain & ~grant[k];
        end
    end

endmodule

// File: rtl/issue_queue_nxm.sv
// rtl/issue_queue_nxm.sv - collapsing age-ordered issue queue, N_IN dispatch / N_OUT issue
//
// i_clk : clock, all state changes on the rising edge
// i_rst : synchronous active-high reset
// bus   : issue_queue_nxm_if.slave (dispatch, wakeup, kill, stall, issue, count)
//
// Valid entries live compactly in slots 0..count-1, oldest first; slot
// validity is derived from the count. DEPTH must be >= N_IN.

module issue_queue_nxm
    import issue_queue_nxm_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int N_IN      = DEF_N_IN,
    parameter int N_OUT     = DEF_N_OUT,
    parameter int N_WB      = DEF_N_WB,
    parameter int WIDTH_TAG = DEF_WIDTH_TAG,
    parameter int WIDTH_BRM = DEF_WIDTH_BRM,
    parameter int WIDTH_PL  = DEF_WIDTH_PL
) (
    input  logic               i_clk,
    input  logic               i_rst,
    issue_queue_nxm_if.slave   bus
);

    localparam int CW = count_w(DEPTH);
    localparam int WP = WIDTH_PL;
    localparam int WT = WIDTH_TAG;
    localparam int WB = WIDTH_BRM;

    // Entry layout, LSB first: brm | src2_rdy | src2_tag | src1_rdy | src1_tag | payload
    localparam int OFF_BRM = 0;
    localparam int OFF_R2  = OFF_BRM + WB;
    localparam int OFF_T2  = OFF_R2 + 1;
    localparam int OFF_R1  = OFF_T2 + WT;
    localparam int OFF_T1  = OFF_R1 + 1;
    localparam int OFF_PL  = OFF_T1 + WT;
    localparam int EW      = OFF_PL + WP;

    logic [EW-1:0]              ent_q   [DEPTH];
    logic [EW-1:0]              ent_nxt [DEPTH];
    logic [CW-1:0]              count_q;
    logic [CW-1:0]              count_nxt;
    logic                       in_ready;

    logic [DEPTH-1:0]           vld;
    logic [DEPTH-1:0]           req;
    logic [DEPTH-1:0]           kill_hit;
    logic [DEPTH-1:0]           issued;
    logic [DEPTH-1:0]           keep;
    logic [DEPTH-1:0]           rdy1_wk;
    logic [DEPTH-1:0]           rdy2_wk;

    logic [N_IN-1:0][EW-1:0]    lane_ent;
    logic [N_IN-1:0]            lane_acc;

    logic [N_OUT-1:0][DEPTH-1:0] grant;
    logic [N_OUT-1:0]            grant_valid;

    int                         wr_ptr;

    // Depends on the registered count only, never on this cycle's issue.
    assign in_ready     = (DEPTH - int'(count_q)) >= N_IN;
    assign bus.o_in_ready = in_ready;
    assign bus.o_count    = count_q;

    // Per-slot status, wakeup and kill compare.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic hit1;
        logic hit2;

        always_comb begin
            hit1 = 1'b0;
            hit2 = 1'b0;
            for (int w = 0; w < N_WB; w++) begin
                if (bus.i_wb_valid[w] && (bus.i_wb_tag[w*WT +: WT] == ent_q[i][OFF_T1 +: WT]))
                    hit1 = 1'b1;
                if (bus.i_wb_valid[w] && (bus.i_wb_tag[w*WT +: WT] == ent_q[i][OFF_T2 +: WT]))
                    hit2 = 1'b1;
            end
        end

        assign vld[i]      = CW'(i) < count_q;
        // Registered ready bits only: a same-cycle wakeup cannot make it eligible.
        assign req[i]      = vld[i] & ent_q[i][OFF_R1] & ent_q[i][OFF_R2];
        assign kill_hit[i] = bus.i_kill_en & (|(ent_q[i][OFF_BRM +: WB] & bus.i_kill_mask));
        assign rdy1_wk[i]  = ent_q[i][OFF_R1] | hit1;
        assign rdy2_wk[i]  = ent_q[i][OFF_R2] | hit2;
    end

    // Incoming lanes see the same wakeup ports so a coincident writeback is not lost.
    for (genvar l = 0; l < N_IN; l++) begin : g_lane
        logic          hit1;
        logic          hit2;
        logic [WT-1:0] tag1;
        logic [WT-1:0] tag2;
        logic [WB-1:0] brm;

        assign tag1 = bus.i_src1_tag[l*WT +: WT];
        assign tag2 = bus.i_src2_tag[l*WT +: WT];
        assign brm  = bus.i_brm[l*WB +: WB];

        always_comb begin
            hit1 = 1'b0;
            hit2 = 1'b0;
            for (int w = 0; w < N_WB; w++) begin
                if (bus.i_wb_valid[w] && (bus.i_wb_tag[w*WT +: WT] == tag1))
                    hit1 = 1'b1;
                if (bus.i_wb_valid[w] && (bus.i_wb_tag[w*WT +: WT] == tag2))
                    hit2 = 1'b1;
            end
        end

        assign lane_acc[l] = in_ready & bus.i_valid[l]
                           & ~(bus.i_kill_en & (|(brm & bus.i_kill_mask)));
        assign lane_ent[l] = {bus.i_payload[l*WP +: WP],
                              tag1, bus.i_src1_rdy[l] | hit1,
                              tag2, bus.i_src2_rdy[l] | hit2,
                              brm};
    end

    iq_select #(
        .DEPTH (DEPTH),
        .N_OUT (N_OUT)
    ) u_select (
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // Issue ports; a stall hides the grants and removes nothing.
    always_comb begin
        bus.o_issue_valid   = '0;
        bus.o_issue_payload = '0;
        bus.o_issue_brm     = '0;
        issued              = '0;
        for (int k = 0; k < N_OUT; k++) begin
            bus.o_issue_valid[k] = grant_valid[k] & ~bus.i_stall;
            for (int i = 0; i < DEPTH; i++) begin
                if (grant[k][i]) begin
                    bus.o_issue_payload[k*WP +: WP] = ent_q[i][OFF_PL +: WP];
                    bus.o_issue_brm[k*WB +: WB]     = ent_q[i][OFF_BRM +: WB];
                end
            end
            if (!bus.i_stall)
                issued = issued | grant[k];
        end
    end

    assign keep = vld & ~issued & ~kill_hit;

    // Collapse: survivors slide down in order, accepted lanes append behind them.
    always_comb begin
        for (int j = 0; j < DEPTH; j++)
            ent_nxt[j] = ent_q[j];
        wr_ptr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (keep[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == wr_ptr) begin
                        ent_nxt[j]         = ent_q[i];
                        ent_nxt[j][OFF_R1] = rdy1_wk[i];
                        ent_nxt[j][OFF_R2] = rdy2_wk[i];
                    end
                end
                wr_ptr = wr_ptr + 1;
            end
        end
        for (int l = 0; l < N_IN; l++) begin
            if (lane_acc[l]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == wr_ptr)
                        ent_nxt[j] = lane_ent[l];
                end
                wr_ptr = wr_ptr + 1;
            end
        end
        count_nxt = CW'(wr_ptr);
    end

    // Slot contents need no reset: validity comes from the count alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
            for (int j = 0; j < DEPTH; j++)
                ent_q[j] <= ent_nxt[j];
        end
    end

endmodule

// File: tb/tb_issue_queue_nxm.sv
// tb/tb_issue_queue_nxm.sv - self-checking bench for issue_queue_nxm

module tb_issue_queue_nxm;

    localparam int DEPTH = 16;
    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int N_WB  = 4;
    localparam int WT    = 6;
    localparam int WB    = 3;
    localparam int WP    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_queue_nxm_if #(
        .DEPTH(DEPTH), .N_IN(N_IN), .N_OUT(N_OUT), .N_WB(N_WB),
        .WIDTH_TAG(WT), .WIDTH_BRM(WB), .WIDTH_PL(WP)
    ) bus ();

    issue_queue_nxm #(
        .DEPTH(DEPTH), .N_IN(N_IN), .N_OUT(N_OUT), .N_WB(N_WB),
        .WIDTH_TAG(WT), .WIDTH_BRM(WB), .WIDTH_PL(WP)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [WP-1:0] pl;
        logic [WT-1:0] t1;
        logic          r1;
        logic [WT-1:0] t2;
        logic          r2;
        logic [WB-1:0] brm;
    } ent_t;

    ent_t q[$];
    int   iss_idx[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    bit   chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        for (int w = 0; w < N_WB; w++) begin
            if (bus.i_wb_valid[w] && bus.i_wb_tag[w*WT +: WT] == e.t1) r.r1 = 1'b1;
            if (bus.i_wb_valid[w] && bus.i_wb_tag[w*WT +: WT] == e.t2) r.r2 = 1'b1;
        end
        return r;
    endfunction

    function automatic bit killed(input logic [WB-1:0] b);
        return bus.i_kill_en && ((b & bus.i_kill_mask) != '0);
    endfunction

    task automatic clear_inputs();
        bus.i_valid     = '0;
        bus.i_payload   = '0;
        bus.i_src1_tag  = '0;
        bus.i_src2_tag  = '0;
        bus.i_src1_rdy  = '0;
        bus.i_src2_rdy  = '0;
        bus.i_brm       = '0;
        bus.i_wb_valid  = '0;
        bus.i_wb_tag    = '0;
        bus.i_kill_en   = 1'b0;
        bus.i_kill_mask = '0;
        bus.i_stall     = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [WP-1:0] pl, input logic [WT-1:0] t1,
                            input logic r1, input logic [WT-1:0] t2, input logic r2,
                            input logic [WB-1:0] brm);
        bus.i_valid[l]             = 1'b1;
        bus.i_payload[l*WP +: WP]  = pl;
        bus.i_src1_tag[l*WT +: WT] = t1;
        bus.i_src1_rdy[l]          = r1;
        bus.i_src2_tag[l*WT +: WT] = t2;
        bus.i_src2_rdy[l]          = r2;
        bus.i_brm[l*WB +: WB]      = brm;
    endtask

    task automatic set_wb(input int w, input logic [WT-1:0] tag);
        bus.i_wb_valid[w]        = 1'b1;
        bus.i_wb_tag[w*WT +: WT] = tag;
    endtask

    // Expected issue set: the N_OUT oldest entries with both operands ready.
    task automatic check_outputs();
        bit exp_v;
        iss_idx.delete();
        if (!bus.i_stall)
            foreach (q[i])
                if (q[i].r1 && q[i].r2 && iss_idx.size() < N_OUT)
                    iss_idx.push_back(i);
        if (chk_on) begin
            chk("count", 64'(bus.o_count), 64'(q.size()));
            chk("in_ready", 64'(bus.o_in_ready), 64'((DEPTH - q.size()) >= N_IN));
            for (int k = 0; k < N_OUT; k++) begin
                exp_v = k < iss_idx.size();
                chk($sformatf("issue_valid%0d", k), 64'(bus.o_issue_valid[k]), 64'(exp_v));
                if (exp_v) begin
                    chk($sformatf("issue_payload%0d", k), 64'(bus.o_issue_payload[k*WP +: WP]),
                        64'(q[iss_idx[k]].pl));
                    chk($sformatf("issue_brm%0d", k), 64'(bus.o_issue_brm[k*WB +: WB]),
                        64'(q[iss_idx[k]].brm));
                end
            end
        end
    endtask

    task automatic model_update();
        ent_t nq[$];
        ent_t e;
        bit   in_rdy;
        bit   gone;
        if (rst) begin
            q.delete();
            return;
        end
        in_rdy = (DEPTH - q.size()) >= N_IN;
        foreach (q[i]) begin
            gone = killed(q[i].brm);
            foreach (iss_idx[j])
                if (iss_idx[j] == i) gone = 1'b1;
            if (!gone) nq.push_back(wake(q[i]));
        end
        for (int l = 0; l < N_IN; l++) begin
            if (in_rdy && bus.i_valid[l]) begin
                e.pl  = bus.i_payload[l*WP +: WP];
                e.t1  = bus.i_src1_tag[l*WT +: WT];
                e.r1  = bus.i_src1_rdy[l];
                e.t2  = bus.i_src2_tag[l*WT +: WT];
                e.r2  = bus.i_src2_rdy[l];
                e.brm = bus.i_brm[l*WB +: WB];
                if (!killed(e.brm)) nq.push_back(wake(e));
            end
        end
        q = nq;
    endtask

    // Entered at a falling edge with inputs already applied.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        clear_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        @(negedge clk);
        cycle();
        rst    = 1'b0;
        chk_on = 1'b1;
        #1;
        chk("reset_count", 64'(bus.o_count), 64'd0);
        chk("reset_in_ready", 64'(bus.o_in_ready), 64'd1);
        chk("reset_issue_valid", 64'(bus.o_issue_valid), 64'd0);

        // Four ready lanes: two issue next cycle, then the third leads.
        for (int l = 0; l < 4; l++) set_lane(l, 32'h100 + l, 6'd0, 1'b1, 6'd0, 1'b1, 3'b000);
        cycle();
        clear_inputs();
        #1;
        chk("d1_count", 64'(bus.o_count), 64'd4);
        chk("d1_model_count", 64'(q.size()), 64'd4);
        chk("d1_valid", 64'(bus.o_issue_valid), 64'b11);
        chk("d1_p0", 64'(bus.o_issue_payload[0 +: WP]), 64'h100);
        chk("d1_p1", 64'(bus.o_issue_payload[WP +: WP]), 64'h101);
        cycle();
        #1;
        chk("d1_count2", 64'(bus.o_count), 64'd2);
        chk("d1_p0_next", 64'(bus.o_issue_payload[0 +: WP]), 64'h102);
        reset_dut();

        // Sparse lanes 1 and 3 compact into slots 0 and 1.
        set_lane(1, 32'h201, 6'd0, 1'b1, 6'd0, 1'b1, 3'b000);
        set_lane(3, 32'h203, 6'd0, 1'b1, 6'd0, 1'b1, 3'b000);
        cycle();
        clear_inputs();
        #1;
        chk("d2_count", 64'(bus.o_count), 64'd2);
        chk("d2_p0", 64'(bus.o_issue_payload[0 +: WP]), 64'h201);
        chk("d2_p1", 64'(bus.o_issue_payload[WP +: WP]), 64'h203);
        reset_dut();

        // Wakeup coincident with dispatch, then wakeup one cycle late.
        set_lane(0, 32'h300, 6'd9, 1'b0, 6'd1, 1'b1, 3'b000);
        set_wb(2, 6'd9);
        cycle();
        clear_inputs();
        #1;
        chk("d3_same_valid", 64'(bus.o_issue_valid), 64'b01);
        chk("d3_same_pl", 64'(bus.o_issue_payload[0 +: WP]), 64'h300);
        cycle();
        set_lane(0, 32'h310, 6'd9, 1'b0, 6'd1, 1'b1, 3'b000);
        cycle();
        clear_inputs();
        set_wb(2, 6'd9);
        #1;
        chk("d3_late_wait", 64'(bus.o_issue_valid), 64'b00);
        cycle();
        clear_inputs();
        #1;
        chk("d3_late_valid", 64'(bus.o_issue_valid), 64'b01);
        chk("d3_late_pl", 64'(bus.o_issue_payload[0 +: WP]), 64'h310);
        reset_dut();

        // Fill to DEPTH-N_IN+1 with only the oldest entry ready.
        for (int g = 0; g < 4; g++) begin
            clear_inputs();
            bus.i_stall = 1'b1;
            for (int l = 0; l < ((g == 3) ? 1 : 4); l++)
                set_lane(l, 32'h400 + g*4 + l, 6'd63, (g == 0 && l == 0), 6'd0, 1'b1, 3'b000);
            cycle();
        end
        clear_inputs();
        bus.i_stall = 1'b1;
        bus.i_valid = 4'hF;
        #1;
        chk("d4_full_ready", 64'(bus.o_in_ready), 64'd0);
        cycle();
        #1;
        chk("d4_hold_count", 64'(bus.o_count), 64'd13);
        bus.i_stall = 1'b0;
        #1;
        chk("d4_one_issue", 64'(bus.o_issue_valid), 64'b01);
        chk("d4_issue_pl", 64'(bus.o_issue_payload[0 +: WP]), 64'h400);
        cycle();
        clear_inputs();
        #1;
        chk("d4_count12", 64'(bus.o_count), 64'd12);
        chk("d4_ready_again", 64'(bus.o_in_ready), 64'd1);
        reset_dut();

        // Kill by mask, with a matching same-cycle dispatch dropped.
        set_lane(0, 32'h500, 6'd63, 1'b0, 6'd0, 1'b1, 3'b001);
        set_lane(1, 32'h501, 6'd63, 1'b0, 6'd0, 1'b1, 3'b010);
        set_lane(2, 32'h502, 6'd63, 1'b0, 6'd0, 1'b1, 3'b000);
        cycle();
        clear_inputs();
        bus.i_kill_en   = 1'b1;
        bus.i_kill_mask = 3'b001;
        set_lane(0, 32'h599, 6'd0, 1'b1, 6'd0, 1'b1, 3'b001);
        cycle();
        clear_inputs();
        #1;
        chk("d5_count", 64'(bus.o_count), 64'd2);
        set_wb(0, 6'd63);
        bus.i_stall = 1'b1;
        cycle();
        clear_inputs();
        #1;
        chk("d5_valid", 64'(bus.o_issue_valid), 64'b11);
        chk("d5_p0", 64'(bus.o_issue_payload[0 +: WP]), 64'h501);
        chk("d5_p1", 64'(bus.o_issue_payload[WP +: WP]), 64'h502);
        chk("d5_brm0", 64'(bus.o_issue_brm[0 +: WB]), 64'b010);
        reset_dut();

        // Stall holds everything; reset beats dispatch and kill.
        bus.i_stall = 1'b1;
        for (int l = 0; l < 3; l++) set_lane(l, 32'h600 + l, 6'd0, 1'b1, 6'd0, 1'b1, 3'b000);
        cycle();
        clear_inputs();
        bus.i_stall = 1'b1;
        #1;
        chk("d6_stall_valid", 64'(bus.o_issue_valid), 64'b00);
        cycle();
        #1;
        chk("d6_stall_count", 64'(bus.o_count), 64'd3);
        for (int l = 0; l < 4; l++) set_lane(l, 32'h610 + l, 6'd0, 1'b1, 6'd0, 1'b1, 3'b000);
        bus.i_kill_en   = 1'b1;
        bus.i_kill_mask = 3'b111;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("d6_rst_count", 64'(bus.o_count), 64'd0);
        chk("d6_rst_ready", 64'(bus.o_in_ready), 64'd1);
        chk("d6_rst_valid", 64'(bus.o_issue_valid), 64'd0);

        // Randomised traffic against the queue model.
        for (int c = 0; c < 3000; c++) begin
            int phase;
            phase = (c / 150) % 3;
            clear_inputs();
            for (int l = 0; l < N_IN; l++)
                if ($urandom % 4 != 0)
                    set_lane(l, $urandom, 6'($urandom_range(0, 7)), 1'($urandom % 2),
                             6'($urandom_range(0, 7)), 1'($urandom % 2),
                             ($urandom % 2 == 0) ? 3'b000 : 3'($urandom_range(0, 7)));
            for (int w = 0; w < N_WB; w++)
                if ($urandom % 3 == 0) set_wb(w, 6'($urandom_range(0, 7)));
            if ($urandom % 10 == 0) begin
                bus.i_kill_en   = 1'b1;
                bus.i_kill_mask = 3'($urandom_range(1, 7));
            end
            bus.i_stall = (phase == 0) ? 1'($urandom % 2) : ($urandom % 8 == 0);
            rst = ($urandom % 400 == 0);
            cycle();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
